// File: rtl/ov7670_config_seq.sv
// Walks the OV7670 configuration ROM and issues one SCCB register write per entry.
// Define CFG_RETRY_EN to retry NACKed writes up to MAX_RETRY times before flagging err.
module ov7670_config_seq #(
    parameter int DELAY_CYCLES = 500000,
    parameter int MAX_RETRY    = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [7:0]  rom_addr,
    input  logic [15:0] rom_dout,
    input  logic        sccb_ready,
    output logic        sccb_start,
    output logic [7:0]  sccb_reg,
    output logic [7:0]  sccb_data,
    input  logic        sccb_done,
    input  logic        sccb_nack,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_SEND   = 3'd3;
    localparam logic [2:0] ST_WAIT   = 3'd4;
    localparam logic [2:0] ST_DELAY  = 3'd5;
    localparam logic [2:0] ST_NEXT   = 3'd6;
    localparam logic [2:0] ST_DONE   = 3'd7;

    localparam logic [15:0] MARK_END   = 16'hFFFF;
    localparam logic [15:0] MARK_DELAY = 16'hFFF0;

    // The counter only ever holds DELAY_CYCLES-1 down to 0.
    localparam int DW = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
    localparam logic [DW-1:0] DELAY_LOAD = DW'(DELAY_CYCLES - 1);

    logic [2:0]    state_reg;
    logic [DW-1:0] delay_cnt_reg;
    logic [7:0]    rom_addr_reg;
    logic          sccb_start_reg;
    logic [7:0]    reg_addr_reg;
    logic [7:0]    reg_val_reg;

`ifdef CFG_RETRY_EN
    localparam int RW = $clog2(MAX_RETRY + 1) + 1;
    localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY);

    logic [RW-1:0] retry_cnt_reg;
    logic          err_reg;

    assign err = err_reg;
`else
    logic nack_unused;

    assign nack_unused = sccb_nack & (MAX_RETRY >= 0);
    assign err         = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            delay_cnt_reg  <= '0;
            rom_addr_reg   <= 8'h00;
            sccb_start_reg <= 1'b0;
            reg_addr_reg   <= 8'h00;
            reg_val_reg    <= 8'h00;
`ifdef CFG_RETRY_EN
            retry_cnt_reg  <= '0;
            err_reg        <= 1'b0;
`endif
        end else begin
            sccb_start_reg <= 1'b0;
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_reg    <= ST_FETCH;
                        rom_addr_reg <= 8'h00;
`ifdef CFG_RETRY_EN
                        retry_cnt_reg <= '0;
                        err_reg       <= 1'b0;
`endif
                    end
                end
                ST_FETCH: begin
                    state_reg <= ST_DECODE;
                end
                ST_DECODE: begin
                    if (rom_dout == MARK_END) begin
                        state_reg <= ST_DONE;
                    end else if (rom_dout == MARK_DELAY) begin
                        delay_cnt_reg <= DELAY_LOAD;
                        state_reg     <= ST_DELAY;
                    end else begin
                        reg_addr_reg <= rom_dout[15:8];
                        reg_val_reg  <= rom_dout[7:0];
                        state_reg    <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (sccb_ready) begin
                        sccb_start_reg <= 1'b1;
                        state_reg      <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (sccb_done) begin
`ifdef CFG_RETRY_EN
                        if (sccb_nack) begin
                            if (retry_cnt_reg == RETRY_LAST) begin
                                err_reg   <= 1'b1;
                                state_reg <= ST_DONE;
                            end else begin
                                // Same entry again: reg/data latches are left untouched.
                                retry_cnt_reg <= retry_cnt_reg + 1'b1;
                                state_reg     <= ST_SEND;
                            end
                        end else begin
                            state_reg <= ST_NEXT;
                        end
`else
                        state_reg <= ST_NEXT;
`endif
                    end
                end
                ST_DELAY: begin
                    if (delay_cnt_reg == '0) begin
                        state_reg <= ST_NEXT;
                    end else begin
                        delay_cnt_reg <= delay_cnt_reg - 1'b1;
                    end
                end
                ST_NEXT: begin
`ifdef CFG_RETRY_EN
                    retry_cnt_reg <= '0;
`endif
                    // A ROM without an end marker stops at the last address rather than wrapping.
                    if (rom_addr_reg == 8'hFF) begin
                        state_reg <= ST_DONE;
                    end else begin
                        rom_addr_reg <= rom_addr_reg + 8'h01;
                        state_reg    <= ST_FETCH;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign rom_addr   = rom_addr_reg;
    assign sccb_start = sccb_start_reg;
    assign sccb_reg   = reg_addr_reg;
    assign sccb_data  = reg_val_reg;
    assign busy       = (state_reg != ST_IDLE) && (state_reg != ST_DONE);
    assign done       = (state_reg == ST_DONE);

endmodule

// File: tb/tb_ov7670_config_seq.sv
// Directed bench for ov7670_config_seq with a synchronous ROM model and a simple SCCB slave.
// Build with or without CFG_RETRY_EN; the NACK scenario expects the matching behaviour.
module tb_ov7670_config_seq;

    localparam int DELAY_CYCLES = 20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  rom_addr;
    logic [15:0] rom_dout;
    logic        sccb_ready;
    logic        sccb_start;
    logic [7:0]  sccb_reg;
    logic [7:0]  sccb_data;
    logic        sccb_done;
    logic        sccb_nack;
    logic        busy;
    logic        done;
    logic        err;

    int total = 0;
    int bad = 0;

    bit ready_en = 1'b1;
    bit nack_on = 1'b0;
    int slave_cnt;
    logic [15:0] rom [256];
    logic [15:0] wr_log [$];

    ov7670_config_seq #(
        .DELAY_CYCLES(DELAY_CYCLES),
        .MAX_RETRY   (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .rom_addr  (rom_addr),
        .rom_dout  (rom_dout),
        .sccb_ready(sccb_ready),
        .sccb_start(sccb_start),
        .sccb_reg  (sccb_reg),
        .sccb_data (sccb_data),
        .sccb_done (sccb_done),
        .sccb_nack (sccb_nack),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_dout <= rom[rom_addr];

    // SCCB slave: busy for four cycles after each start, then a one-cycle done.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slave_cnt <= 0;
            sccb_done <= 1'b0;
            sccb_nack <= 1'b0;
        end else begin
            sccb_done <= 1'b0;
            sccb_nack <= 1'b0;
            if (sccb_start) begin
                wr_log.push_back({sccb_reg, sccb_data});
                $display("write reg=%h data=%h t=%0t", sccb_reg, sccb_data, $time);
                slave_cnt <= 4;
            end else if (slave_cnt != 0) begin
                slave_cnt <= slave_cnt - 1;
                if (slave_cnt == 1) begin
                    sccb_done <= 1'b1;
                    sccb_nack <= nack_on;
                end
            end
        end
    end

    assign sccb_ready = ready_en && (slave_cnt == 0);

    task automatic load_basic_rom();
        for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;
        rom[0] = 16'h1280;
        rom[1] = 16'hFFF0;
        rom[2] = 16'h1204;
        rom[3] = 16'hFFFF;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        @(negedge clk);
        total++;
        if ({rom_addr, sccb_start, sccb_reg, sccb_data, busy, done, err} !== 28'h0) begin
            bad++;
            $display("FAIL reset_outputs: got addr=%h st=%b reg=%h data=%h busy=%b done=%b err=%b want all 0",
                     rom_addr, sccb_start, sccb_reg, sccb_data, busy, done, err);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        bit ok;
        int lat;
        int gap;
        load_basic_rom();
        wr_log.delete();
        pulse_start();
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy: got %b want 1", busy); end
        lat = -1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (sccb_start) begin lat = k; break; end
        end
        total++;
        if (lat != 3) begin bad++; $display("FAIL basic_latency: got %0d want 3", lat); end
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (sccb_done) break;
        end
        // done seen, then WAIT, NEXT, FETCH, DECODE, DELAY x N, NEXT before address 2 appears
        gap = -1;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (rom_addr == 8'd2) begin gap = k; break; end
        end
        total++;
        if (gap != DELAY_CYCLES + 5) begin bad++; $display("FAIL basic_delay_gap: got %0d want %0d", gap, DELAY_CYCLES + 5); end
        wait_done(500, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL basic_timeout: got no done want done"); end
        total++;
        if (wr_log.size() != 2) begin
            bad++; $display("FAIL basic_count: got %0d want 2", wr_log.size());
        end else if (wr_log[0] !== 16'h1280 || wr_log[1] !== 16'h1204) begin
            bad++; $display("FAIL basic_order: got %h %h want 1280 1204", wr_log[0], wr_log[1]);
        end
        total++;
        if ({rom_addr, done, busy, err} !== {8'd3, 1'b1, 1'b0, 1'b0}) begin
            bad++; $display("FAIL basic_final: got addr=%h done=%b busy=%b err=%b want 03 1 0 0", rom_addr, done, busy, err);
        end
    endtask

    task automatic test_ready_stall();
        bit ok;
        int viol;
        load_basic_rom();
        wr_log.delete();
        ready_en = 1'b0;
        pulse_start();
        @(negedge clk);
        @(negedge clk);
        viol = 0;
        for (int k = 0; k < 50; k++) begin
            if (sccb_start !== 1'b0 || {sccb_reg, sccb_data} !== 16'h1280) viol++;
            @(negedge clk);
        end
        total++;
        if (viol != 0) begin bad++; $display("FAIL stall_hold: got %0d bad cycles want 0", viol); end
        ready_en = 1'b1;
        @(negedge clk);
        total++;
        if (sccb_start !== 1'b1) begin bad++; $display("FAIL stall_release: got start=%b want 1", sccb_start); end
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (sccb_done) begin ok = 1'b1; break; end
        end
        total++;
        if (!ok || {sccb_reg, sccb_data} !== 16'h1280) begin
            bad++; $display("FAIL stall_stable_at_done: got seen=%b %h want 1 1280", ok, {sccb_reg, sccb_data});
        end
        wait_done(500, ok);
        total++;
        if (!ok || wr_log.size() != 2) begin bad++; $display("FAIL stall_finish: got done=%b writes=%0d want 1 2", ok, wr_log.size()); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        load_basic_rom();
        pulse_start();
        for (int k = 0; k < 100; k++) begin
            if (rom_addr == 8'd1) break;
            @(negedge clk);
        end
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if ({rom_addr, sccb_start, sccb_reg, sccb_data, busy, done, err} !== 28'h0) begin
            bad++;
            $display("FAIL midreset_outputs: got addr=%h st=%b reg=%h data=%h busy=%b done=%b err=%b want all 0",
                     rom_addr, sccb_start, sccb_reg, sccb_data, busy, done, err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        wr_log.delete();
        pulse_start();
        total++;
        if (rom_addr !== 8'd0 || busy !== 1'b1) begin
            bad++; $display("FAIL midreset_restart: got addr=%h busy=%b want 00 1", rom_addr, busy);
        end
        wait_done(500, ok);
        total++;
        if (!ok || wr_log.size() != 2) begin
            bad++; $display("FAIL midreset_pass: got done=%b writes=%0d want 1 2", ok, wr_log.size());
        end else if (wr_log[0] !== 16'h1280 || wr_log[1] !== 16'h1204) begin
            bad++; $display("FAIL midreset_order: got %h %h want 1280 1204", wr_log[0], wr_log[1]);
        end
    endtask

    task automatic test_no_end();
        bit ok;
        int wrong;
        for (int i = 0; i < 256; i++) rom[i] = 16'h0100;
        wr_log.delete();
        pulse_start();
        wait_done(10000, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL noend_timeout: got no done want done"); end
        repeat (5) @(negedge clk);
        wrong = 0;
        foreach (wr_log[i]) if (wr_log[i] !== 16'h0100) wrong++;
        total++;
        if (wr_log.size() != 256 || wrong != 0) begin
            bad++; $display("FAIL noend_writes: got %0d writes %0d wrong want 256 0", wr_log.size(), wrong);
        end
        total++;
        if (rom_addr !== 8'hFF || done !== 1'b1) begin
            bad++; $display("FAIL noend_addr: got addr=%h done=%b want ff 1", rom_addr, done);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        load_basic_rom();
        wr_log.delete();
        pulse_start();
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (sccb_start) break;
        end
        pulse_start();
        wait_done(500, ok);
        total++;
        if (!ok || wr_log.size() != 2) begin
            bad++; $display("FAIL b2b_ignored_start: got done=%b writes=%0d want 1 2", ok, wr_log.size());
        end
        pulse_start();
        total++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            bad++; $display("FAIL b2b_restart: got done=%b busy=%b want 0 1", done, busy);
        end
        wait_done(500, ok);
        total++;
        if (!ok || wr_log.size() != 4) begin
            bad++; $display("FAIL b2b_second_count: got done=%b writes=%0d want 1 4", ok, wr_log.size());
        end else if (wr_log[2] !== 16'h1280 || wr_log[3] !== 16'h1204) begin
            bad++; $display("FAIL b2b_second_order: got %h %h want 1280 1204", wr_log[2], wr_log[3]);
        end
    endtask

    task automatic test_nack();
        bit ok;
        int wrong;
        load_basic_rom();
        wr_log.delete();
        nack_on = 1'b1;
        pulse_start();
        wait_done(1000, ok);
        nack_on = 1'b0;
        wrong = 0;
`ifdef CFG_RETRY_EN
        foreach (wr_log[i]) if (wr_log[i] !== 16'h1280) wrong++;
        total++;
        if (!ok || wr_log.size() != 4 || wrong != 0) begin
            bad++; $display("FAIL nack_retries: got done=%b writes=%0d wrong=%0d want 1 4 0", ok, wr_log.size(), wrong);
        end
        total++;
        if (err !== 1'b1 || rom_addr !== 8'd0) begin
            bad++; $display("FAIL nack_err: got err=%b addr=%h want 1 00", err, rom_addr);
        end
`else
        total++;
        if (!ok || wr_log.size() != 2) begin
            bad++; $display("FAIL nack_ignored: got done=%b writes=%0d want 1 2", ok, wr_log.size());
        end
        total++;
        if (err !== 1'b0 || rom_addr !== 8'd3) begin
            bad++; $display("FAIL nack_err: got err=%b addr=%h want 0 03", err, rom_addr);
        end
`endif
        pulse_start();
        total++;
        if (err !== 1'b0) begin bad++; $display("FAIL nack_err_clear: got %b want 0", err); end
        wait_done(500, ok);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ready_stall();
        test_reset_mid();
        test_no_end();
        test_back_to_back();
        test_nack();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
